// File: rtl/sum_pkg.sv
// Shared types for the summing arbiter: FSM state encoding and default data width.
// No logic; latency n/a; backpressure n/a.
package sum_pkg;

  localparam int SUM_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sum_accum.sv
// Session accumulator: clear, conditional add, wrap or saturate (SUM_SAT_EN).
// Latency: result visible one cycle after add_en.
// Backpressure: none; holds its value whenever add_en and clr are low.
module sum_accum
  import sum_pkg::*;
#(
  parameter int W = SUM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_nxt;

`ifdef SUM_SAT_EN
  logic [W:0] acc_ext;

  // The carry out of the widened add marks overflow; pin to all-ones from then on.
  always_comb begin
    acc_ext = {1'b0, acc} + {1'b0, din};
    acc_nxt = acc_ext[W] ? {W{1'b1}} : acc_ext[W-1:0];
  end
`else
  always_comb begin
    acc_nxt = acc + din;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/sum_arbiter.sv
// Round-robin arbiter granting one requester a zero-terminated summing session (SUM_SAT_EN saturates).
// Latency: done pulses k+3 cycles after req rises for k nonzero words plus terminator.
// Backpressure: none; non-granted requesters wait at req level, dropping req aborts the session.
module sum_arbiter
  import sum_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = SUM_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       data,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [W-1:0]            sum
);

  localparam int IDW = $clog2(NREQ);

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] last_id;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  logic           win_vld;
  logic           cur_req;
  logic [W-1:0]   cur_data;
  logic [W-1:0]   acc;
  logic           start;
  logic           abort;
  logic           finish;
  logic           acc_clr;
  logic           acc_add;

  // Search starts just above the previous owner so every requester eventually wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_id) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    cur_req  = req[cur_id];
    cur_data = data[int'(cur_id)*W +: W];
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    finish    = 1'b0;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = ACC;
          start     = 1'b1;
          acc_clr   = 1'b1;
        end
      end
      ACC: begin
        if (!cur_req) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (cur_data == '0) begin
          state_nxt = DONE;
        end else begin
          acc_add = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        finish    = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      cur_id  <= '0;
      last_id <= IDW'(NREQ - 1);
      done    <= 1'b0;
      done_id <= '0;
      sum     <= '0;
    end else begin
      done <= finish;
      if (start) begin
        cur_id <= win_id;
        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
      end else if (state_nxt != ACC) begin
        gnt <= '0;
      end
      if (finish || abort) begin
        last_id <= cur_id;
      end
      // An aborted session never reaches here, so sum keeps the last completed result.
      if (finish) begin
        done_id <= cur_id;
        sum     <= acc;
      end
    end
  end

  sum_accum #(
    .W(W)
  ) u_accum (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .add_en(acc_add),
    .din   (cur_data),
    .acc   (acc)
  );

endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: scripted requesters answer grants, a session-level model predicts gnt/done/sum.
module tb_sum_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam logic [16:0] DROP = 17'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  gnt;
  logic        done;
  logic [1:0]  done_id;
  logic [15:0] sum;

  always #5 clk = ~clk;

  sum_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data   (data),
    .gnt    (gnt),
    .done   (done),
    .done_id(done_id),
    .sum    (sum)
  );

  int checks   = 0;
  int failures = 0;

  // Per-requester script; bit 16 set means "drop req instead of sending a word".
  logic [16:0] wq [NREQ][$];

  int       n         = 0;
  int       next_arb  = 1 << 30;
  int       gnt_off   = -1;
  int       done_edge = -1;
  bit       pend_done = 1'b0;
  int       pend_id   = 0;
  int       pend_sum  = 0;
  int       last_m    = NREQ - 1;
  logic [3:0] exp_gnt = '0;
  logic     exp_done  = 1'b0;
  int       exp_id    = 0;
  int       exp_sum   = 0;
  bit       armed     = 1'b0;

  int exp_ids [4] = '{0, 2, 0, 2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int add_w(input int s, input int w);
`ifdef SUM_SAT_EN
    return (s + w > 65535) ? 65535 : s + w;
`else
    return (s + w) % 65536;
`endif
  endfunction

  // Whole-session prediction made at the arbitration edge from the winner's script.
  task automatic model_step();
    int  w;
    int  len;
    int  s;
    bit  ab;
    n++;
    exp_done = 1'b0;
    if (rst) begin
      next_arb  = n + 1;
      pend_done = 1'b0;
      exp_gnt   = '0;
      exp_sum   = 0;
      exp_id    = 0;
      last_m    = NREQ - 1;
      gnt_off   = -1;
    end else begin
      if (n == gnt_off) exp_gnt = '0;
      if (pend_done && n == done_edge) begin
        exp_done  = 1'b1;
        exp_id    = pend_id;
        exp_sum   = pend_sum;
        pend_done = 1'b0;
      end
      if (n >= next_arb && req != 4'b0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          if (w < 0 && req[(last_m + k) % NREQ]) w = (last_m + k) % NREQ;
        end
        len = wq[w].size();
        s   = 0;
        ab  = 1'b0;
        for (int j = 0; j < wq[w].size(); j++) begin
          if (wq[w][j][16]) begin
            ab  = 1'b1;
            len = j;
            break;
          end
          if (wq[w][j][15:0] == 16'h0) begin
            len = j;
            break;
          end
          s = add_w(s, int'(wq[w][j][15:0]));
        end
        exp_gnt = 4'b0001 << w;
        gnt_off = n + len + 1;
        last_m  = w;
        if (ab) begin
          next_arb = n + len + 2;
        end else begin
          pend_done = 1'b1;
          pend_id   = w;
          pend_sum  = s;
          done_edge = n + len + 2;
          next_arb  = n + len + 3;
        end
      end
    end
  endtask

  task automatic drive_step();
    logic [16:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        e = (wq[i].size() > 0) ? wq[i].pop_front() : 17'h0;
        if (e[16]) begin
          req[i] = 1'b0;
          data[i*W +: W] = 16'h5A5A;
        end else begin
          data[i*W +: W] = e[15:0];
        end
      end else begin
        data[i*W +: W] = 16'($urandom_range(1, 65535));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drive_step();
  endtask

  task automatic reset_dut();
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) wq[i].delete();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("cyc_gnt", gnt, exp_gnt);
        chk("cyc_done", done, exp_done);
        chk("cyc_sum", sum, exp_sum);
        if (exp_done) chk("cyc_done_id", done_id, exp_id);
        checks++;
        if ($countones(gnt) > 1) begin
          failures++;
          $display("FAIL gnt_onehot: got %b, expected at most one bit set", gnt);
        end
      end
    end
  end

  initial begin
    int nd;
    rst  = 1'b1;
    req  = '0;
    data = '0;
    tick();
    armed = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_sum", sum, 0);

    // Words 5,7,0 from requester 0.
    wq[0].push_back(17'h5); wq[0].push_back(17'h7); wq[0].push_back(17'h0);
    req = 4'b0001;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 1) chk("s030_gnt", gnt, 4'b0001);
      if (t == 4) chk("s030_nodone_early", done, 0);
      if (t == 5) begin
        chk("s030_done", done, 1);
        chk("s030_sum", sum, 12);
        chk("s030_id", done_id, 0);
        req = '0;
      end
    end

    // Immediate terminator from requester 1.
    wq[1].push_back(17'h0);
    req = 4'b0010;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t == 2) chk("s035_nodone_early", done, 0);
      if (t == 3) begin
        chk("s035_done", done, 1);
        chk("s035_sum", sum, 0);
        chk("s035_id", done_id, 1);
        req = '0;
      end
    end

    // Requesters 0 and 2 alternate.
    reset_dut();
    for (int r = 0; r < 2; r++) begin
      wq[0].push_back(17'h1); wq[0].push_back(17'h0);
      wq[2].push_back(17'h1); wq[2].push_back(17'h0);
    end
    req = 4'b0101;
    nd  = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (done) begin
        if (nd < 4) chk("s031_id", done_id, exp_ids[nd]);
        chk("s031_sum", sum, 1);
        nd++;
      end
    end
    req = '0;
    chk("s031_count", nd, 4);

    // Requester 1 aborts after 3,4; requester 3 then beats requester 0.
    reset_dut();
    wq[1].push_back(17'h3); wq[1].push_back(17'h4); wq[1].push_back(DROP);
    wq[3].push_back(17'h0);
    req = 4'b1010;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 1) chk("s032_gnt1", gnt, 4'b0010);
      if (t == 4) begin
        chk("s032_gnt_off", gnt, 0);
        chk("s032_nodone", done, 0);
        chk("s032_sum_kept", sum, 0);
        req[0] = 1'b1;
      end
      if (t == 5) chk("s032_next_winner", gnt, 4'b1000);
      if (t == 7) begin
        chk("s032_done_id", done_id, 3);
        req = '0;
      end
    end

    // Overflow: FFF0 + 0020.
    wq[0].push_back(17'hFFF0); wq[0].push_back(17'h0020); wq[0].push_back(17'h0);
    req = 4'b0001;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 5) begin
        chk("s033_done", done, 1);
`ifdef SUM_SAT_EN
        chk("s033_sum", sum, 16'hFFFF);
`else
        chk("s033_sum", sum, 16'h0010);
`endif
        req = '0;
      end
    end

    // Reset mid-session, then a clean session from requester 0.
    wq[0].push_back(17'h2); wq[0].push_back(17'h3);
    wq[0].push_back(17'h9); wq[0].push_back(17'h0);
    req = 4'b0001;
    for (int t = 1; t <= 10; t++) begin
      if (t == 4) rst = 1'b1;
      tick();
      if (t == 4) begin
        rst = 1'b0;
        chk("s034_gnt", gnt, 0);
        chk("s034_sum", sum, 0);
        chk("s034_done", done, 0);
        wq[0].delete();
        wq[0].push_back(17'h6); wq[0].push_back(17'hA); wq[0].push_back(17'h0);
      end
      if (t == 5) chk("s034_regrant", gnt, 4'b0001);
      if (t == 9) begin
        chk("s034_done2", done, 1);
        chk("s034_sum2", sum, 16);
        chk("s034_id2", done_id, 0);
        req = '0;
      end
    end

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
